// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory boot loader.
//   state_t   - loader FSM states
//   SYNC_BYTE - frame start marker
//   BYTE_W / WORD_W / LEN_W - stream byte, instruction word and frame-length widths
package imem_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;
    localparam int unsigned LEN_W  = 16;

    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCheck,
        StDone,
        StError
    } state_t;

endpackage

// File: rtl/imem_loader_timer.sv
// imem_loader_timer: inter-byte timeout counter for the boot loader.
// Only instantiated when IMEM_LOADER_TIMEOUT_EN is defined.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-high reset
//   active  in  loader is mid-frame; counter runs only while set
//   clear   in  a byte was accepted this cycle
//   expired out counter has run for TIMEOUT_CYCLES idle cycles
module imem_loader_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic clear,
    output logic expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q, count_d;

    // count_q idle cycles have already elapsed; this cycle is the last one allowed.
    assign expired = active && !clear && (count_q >= CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        count_d = count_q;
        if (!active || clear) begin
            count_d = '0;
        end else if (!expired) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader writing 16-bit words into instruction memory.
// Frame: 0xA5, LEN_HI, LEN_LO, LEN words (high byte first), XOR checksum of data bytes.
// Optional macro IMEM_LOADER_TIMEOUT_EN adds an inter-byte timeout (imem_loader_timer).
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_data     byte stream input, in_ready handshake output
//   imem_we/addr/wdata   one-cycle instruction memory write port (addr always even)
//   cpu_hold             holds the CPU in reset until a verified load
//   done / error         frame verified / frame rejected, both held until rst
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W         = 16,
    parameter int unsigned       MAX_WORDS      = 256,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [BYTE_W-1:0] in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [WORD_W-1:0] imem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    state_t state_q, state_d;

    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  idx_q, idx_d;
    logic [BYTE_W-1:0] hi_q, hi_d;
    logic [BYTE_W-1:0] csum_q, csum_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;

    logic              accept;
    logic              mid_frame;
    logic              timeout;
    logic [LEN_W-1:0]  len_full;

    assign accept    = in_valid && in_ready;
    assign mid_frame = state_q inside {StLenHi, StLenLo, StDataHi, StDataLo, StCheck};
    assign len_full  = {len_q[LEN_W-1:BYTE_W], in_data};

`ifdef IMEM_LOADER_TIMEOUT_EN
    imem_loader_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .active (mid_frame),
        .clear  (accept),
        .expired(timeout)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (accept) begin
            unique case (state_q)
                StIdle:   if (in_data == SYNC_BYTE) state_d = StLenHi;
                StLenHi:  state_d = StLenLo;
                StLenLo: begin
                    if (32'(len_full) > MAX_WORDS) begin
                        state_d = StError;
                    end else if (len_full == '0) begin
                        state_d = StCheck;
                    end else begin
                        state_d = StDataHi;
                    end
                end
                StDataHi: state_d = StDataLo;
                StDataLo: state_d = (idx_q + LEN_W'(1) == len_q) ? StCheck : StDataHi;
                StCheck:  state_d = (in_data == csum_q) ? StDone : StError;
                default:  state_d = state_q;
            endcase
        end else if (timeout && mid_frame) begin
            state_d = StError;
        end
    end

    // Output logic
    always_comb begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        done     = 1'b0;
        error    = 1'b0;
        unique case (state_q)
            StDone: begin
                in_ready = 1'b0;
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            StError: begin
                in_ready = 1'b0;
                error    = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: length, word assembly, checksum and the registered write port
    always_comb begin
        len_d   = len_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        csum_d  = csum_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (accept) begin
            unique case (state_q)
                StLenHi:  len_d[LEN_W-1:BYTE_W] = in_data;
                StLenLo:  len_d[BYTE_W-1:0] = in_data;
                StDataHi: begin
                    hi_d   = in_data;
                    csum_d = csum_q ^ in_data;
                end
                StDataLo: begin
                    csum_d  = csum_q ^ in_data;
                    we_d    = 1'b1;
                    wdata_d = {hi_q, in_data};
                    addr_d  = BASE_ADDR + ADDR_W'({idx_q, 1'b0});
                    idx_d   = idx_q + LEN_W'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            csum_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            len_q   <= len_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            csum_q  <= csum_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // A write owed by an accepted lo byte is dropped if rst arrives in its cycle.
    assign imem_we    = we_q && !rst;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [15:0] imem_addr;
    logic [15:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] wr_addr[$];
    logic [15:0] wr_data[$];

    always #5 clk = ~clk;

    imem_loader #(
        .ADDR_W        (16),
        .MAX_WORDS     (256),
        .BASE_ADDR     (16'h0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_hold  (cpu_hold),
        .done      (done),
        .error     (error)
    );

    // Log every write strobe away from the active edge.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr.push_back(imem_addr);
            wr_data.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] wa(input int i);
        return (wr_addr.size() > i) ? wr_addr[i] : 16'hxxxx;
    endfunction

    function automatic logic [15:0] wd(input int i);
        return (wr_data.size() > i) ? wr_data[i] : 16'hxxxx;
    endfunction

    task automatic send(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr_addr.delete();
        wr_data.delete();
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'h0000);
        check("rst_wdata", 32'(imem_wdata), 32'h0000);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        rst = 1'b0;

        // Two-word frame at full rate; XOR(12,34,AB,CD) = 40
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
        check("f1_we0", 32'(imem_we), 32'd1);
        check("f1_addr0", 32'(imem_addr), 32'h0000);
        check("f1_data0", 32'(imem_wdata), 32'h1234);
        check("f1_ready_wr", 32'(in_ready), 32'd1);
        send(8'hAB);
        check("f1_we_gap", 32'(imem_we), 32'd0);
        send(8'hCD);
        check("f1_we1", 32'(imem_we), 32'd1);
        check("f1_addr1", 32'(imem_addr), 32'h0002);
        check("f1_data1", 32'(imem_wdata), 32'hABCD);
        send(8'h40);
        check("f1_done", 32'(done), 32'd1);
        check("f1_hold", 32'(cpu_hold), 32'd0);
        check("f1_ready", 32'(in_ready), 32'd0);
        check("f1_we_done", 32'(imem_we), 32'd0);
        send(8'hA5);
        idle(3);
        check("f1_nwr", 32'(wr_addr.size()), 32'd2);
        check("f1_w0a", 32'(wa(0)), 32'h0000);
        check("f1_w0d", 32'(wd(0)), 32'h1234);
        check("f1_w1a", 32'(wa(1)), 32'h0002);
        check("f1_w1d", 32'(wd(1)), 32'hABCD);
        check("f1_done_held", 32'(done), 32'd1);
        check("f1_err", 32'(error), 32'd0);

        // Same frame, bad checksum
        do_reset();
        send(8'hA5); send(8'h00); send(8'h02); send(8'h12); send(8'h34);
        send(8'hAB); send(8'hCD); send(8'h41);
        idle(2);
        check("f2_nwr", 32'(wr_addr.size()), 32'd2);
        check("f2_w1d", 32'(wd(1)), 32'hABCD);
        check("f2_err", 32'(error), 32'd1);
        check("f2_hold", 32'(cpu_hold), 32'd1);
        check("f2_done", 32'(done), 32'd0);
        check("f2_ready", 32'(in_ready), 32'd0);

        // Leading garbage, then a one-word frame with a stall mid-frame; XOR(BE,EF) = 51
        do_reset();
        send(8'h00); send(8'hFF);
        check("f3_garbage_ready", 32'(in_ready), 32'd1);
        send(8'hA5); send(8'h00);
        in_data = 8'hA5;
        idle(3);
        send(8'h01); send(8'hBE); send(8'hEF); send(8'h51);
        idle(2);
        check("f3_done", 32'(done), 32'd1);
        check("f3_nwr", 32'(wr_addr.size()), 32'd1);
        check("f3_w0a", 32'(wa(0)), 32'h0000);
        check("f3_w0d", 32'(wd(0)), 32'hBEEF);

        // Length 257 rejected right after LEN_LO
        do_reset();
        send(8'hA5); send(8'h01);
        check("f4_pre_err", 32'(error), 32'd0);
        send(8'h01);
        check("f4_err", 32'(error), 32'd1);
        check("f4_hold", 32'(cpu_hold), 32'd1);
        send(8'h00); send(8'h00);
        idle(2);
        check("f4_nwr", 32'(wr_addr.size()), 32'd0);

        // Zero-length frames
        do_reset();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00);
        idle(2);
        check("f5_done", 32'(done), 32'd1);
        check("f5_nwr", 32'(wr_addr.size()), 32'd0);
        do_reset();
        send(8'hA5); send(8'h00); send(8'h00); send(8'h01);
        idle(1);
        check("f5b_err", 32'(error), 32'd1);
        check("f5b_done", 32'(done), 32'd0);

        // rst in the write cycle owed by the lo byte
        do_reset();
        send(8'hA5); send(8'h00); send(8'h01); send(8'h12); send(8'h34);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("f6_we_cancel", 32'(imem_we), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("f6_nwr", 32'(wr_addr.size()), 32'd0);
        check("f6_addr", 32'(imem_addr), 32'h0000);
        check("f6_wdata", 32'(imem_wdata), 32'h0000);
        check("f6_ready", 32'(in_ready), 32'd1);
        check("f6_hold", 32'(cpu_hold), 32'd1);
        check("f6_done", 32'(done), 32'd0);
        check("f6_error", 32'(error), 32'd0);
        send(8'hA5); send(8'h00); send(8'h01); send(8'h12); send(8'h34); send(8'h26);
        idle(2);
        check("f6_reload_done", 32'(done), 32'd1);
        check("f6_reload_nwr", 32'(wr_addr.size()), 32'd1);
        check("f6_reload_w0d", 32'(wd(0)), 32'h1234);

`ifdef IMEM_LOADER_TIMEOUT_EN
        // Stall after LEN_HI: the 16th idle cycle triggers the timeout
        do_reset();
        send(8'hA5); send(8'h00);
        idle(15);
        check("f7_pre_timeout", 32'(error), 32'd0);
        idle(1);
        check("f7_timeout", 32'(error), 32'd1);
        check("f7_hold", 32'(cpu_hold), 32'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
